centroid_accum: RTL

CENTROID_ACCUM -- requirements
Module: centroid_accum

---
 rtl/centroid_accum.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/centroid_accum.sv
`default_nettype none
// ============================================================================
//  Module      : centroid_accum
//  Description : Accumulates the coordinates of thresholded mask hits over a
//                frame, then runs two serial restoring divisions in parallel
//                with the next frame to produce the hit centroid.
//  Revision    : 1.0  initial release
// ============================================================================
module centroid_accum #(
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768,
  parameter int MIN_COUNT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  mask,
  output logic [10:0] centroid_x,
  output logic [9:0]  centroid_y,
  output logic [19:0] hit_count,
  output logic        found,
  output logic        centroid_valid,
  output logic        overrun
);

  localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);
  localparam logic [4:0]  LAST_IT = 5'd29;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [19:0] count_q, count_d;
  logic [29:0] quo_x_q, quo_x_d, quo_y_q, quo_y_d;
  logic [19:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [19:0] div_cnt_q, div_cnt_d;
  logic [4:0]  iter_q, iter_d;
  logic        commit_q, commit_d;
  logic [10:0] centroid_x_q, centroid_x_d;
  logic [9:0]  centroid_y_q, centroid_y_d;
  logic [19:0] hit_count_q, hit_count_d;
  logic        found_q, found_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic        hit, frame_end;
  logic [29:0] sum_x_inc, sum_y_inc;
  logic [19:0] count_inc;

  // One restoring-division step: shift in the dividend MSB, subtract the
  // divisor when it fits, and shift the quotient bit into the dividend LSB.
  function automatic logic [49:0] div_step(input logic [19:0] rem,
                                           input logic [29:0] quo,
                                           input logic [19:0] dvs);
    logic [20:0] sh;
    logic        qbit;
    sh   = {rem, quo[29]};
    qbit = (sh >= {1'b0, dvs});
    if (qbit) sh = sh - {1'b0, dvs};
    return {sh[19:0], quo[28:0], qbit};
  endfunction

  // Classify the current sample and form the accumulator sums including it.
  always_comb begin
    hit       = pix_valid && (mask != 8'd0) &&
                ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);
    frame_end = pix_valid && (hcount == H_LAST) && (vcount == V_LAST);
    sum_x_inc = sum_x_q + (hit ? 30'(hcount) : 30'd0);
    sum_y_inc = sum_y_q + (hit ? 30'(vcount) : 30'd0);
    count_inc = count_q + (hit ? 20'd1 : 20'd0);
  end

  // Accumulators run continuously; a frame end always restarts them from zero,
  // whether the frame is handed to the divider or dropped as an overrun.
  always_comb begin
    sum_x_d = sum_x_inc;
    sum_y_d = sum_y_inc;
    count_d = count_inc;
    if (frame_end) begin
      sum_x_d = 30'd0;
      sum_y_d = 30'd0;
      count_d = 20'd0;
    end
  end

  // Control FSM and divider datapath: snapshot, 30 iterations, then commit.
  always_comb begin
    state_d   = state_q;
    quo_x_d   = quo_x_q;
    quo_y_d   = quo_y_q;
    rem_x_d   = rem_x_q;
    rem_y_d   = rem_y_q;
    div_cnt_d = div_cnt_q;
    iter_d    = iter_q;
    commit_d  = 1'b0;
    overrun_d = frame_end && (state_q != ST_ACCUM);
    case (state_q)
      ST_ACCUM: begin
        if (frame_end) begin
          state_d   = ST_DIVIDE;
          quo_x_d   = sum_x_inc;
          quo_y_d   = sum_y_inc;
          rem_x_d   = 20'd0;
          rem_y_d   = 20'd0;
          div_cnt_d = count_inc;
          iter_d    = 5'd0;
        end
      end
      ST_DIVIDE: begin
        {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, div_cnt_q);
        {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, div_cnt_q);
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_IT) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d  = ST_ACCUM;
        commit_d = 1'b1;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Output stage: publish the finished frame one cycle after DONE.
  always_comb begin
    centroid_x_d = centroid_x_q;
    centroid_y_d = centroid_y_q;
    hit_count_d  = hit_count_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    if (commit_q) begin
      valid_d     = 1'b1;
      hit_count_d = div_cnt_q;
      found_d     = (div_cnt_q >= MIN_CNT);
      if (div_cnt_q >= MIN_CNT) begin
        centroid_x_d = quo_x_q[10:0];
        centroid_y_d = quo_y_q[9:0];
      end
    end
  end

  // State registers; asynchronous reset aborts any division in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACCUM;
      sum_x_q      <= 30'd0;
      sum_y_q      <= 30'd0;
      count_q      <= 20'd0;
      quo_x_q      <= 30'd0;
      quo_y_q      <= 30'd0;
      rem_x_q      <= 20'd0;
      rem_y_q      <= 20'd0;
      div_cnt_q    <= 20'd0;
      iter_q       <= 5'd0;
      commit_q     <= 1'b0;
      centroid_x_q <= 11'd0;
      centroid_y_q <= 10'd0;
      hit_count_q  <= 20'd0;
      found_q      <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_x_q      <= sum_x_d;
      sum_y_q      <= sum_y_d;
      count_q      <= count_d;
      quo_x_q      <= quo_x_d;
      quo_y_q      <= quo_y_d;
      rem_x_q      <= rem_x_d;
      rem_y_q      <= rem_y_d;
      div_cnt_q    <= div_cnt_d;
      iter_q       <= iter_d;
      commit_q     <= commit_d;
      centroid_x_q <= centroid_x_d;
      centroid_y_q <= centroid_y_d;
      hit_count_q  <= hit_count_d;
      found_q      <= found_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign centroid_x     = centroid_x_q;
  assign centroid_y     = centroid_y_q;
  assign hit_count      = hit_count_q;
  assign found          = found_q;
  assign centroid_valid = valid_q;
  assign overrun        = overrun_q;

endmodule
`default_nettype wire
